// File: rtl/cache_ctrl_pkg.sv
// Shared types and default geometry for the direct-mapped tag cache controller.
// Imported by cache_ctrl and cache_ctrl_stats.
package cache_ctrl_pkg;

   localparam int INDEX_W_DEF = 14;
   localparam int TAG_W_DEF   = 18;
   localparam int ADDR_W_DEF  = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      FILL   = 2'd2,
      RESP   = 2'd3
   } state_t;

endpackage

// File: rtl/cache_ctrl_stats.sv
// Pair of saturating hit/miss counters, each bumped by a one-cycle increment strobe.
// Built only when CACHE_CTRL_STATS_EN is defined.
module cache_ctrl_stats
   import cache_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hit_inc,
   input  logic             miss_inc,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] miss_cnt
);

   // Counters stick at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (hit_inc && (hit_cnt != {CNT_W{1'b1}}))
            hit_cnt <= hit_cnt + CNT_W'(1);
         if (miss_inc && (miss_cnt != {CNT_W{1'b1}}))
            miss_cnt <= miss_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/cache_ctrl.sv
// Request-side controller for the direct-mapped tag cache: lookup, fill on miss, hit/miss response.
// Optional statistics counters are enabled with the CACHE_CTRL_STATS_EN macro.
module cache_ctrl
   import cache_ctrl_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int INDEX_W = INDEX_W_DEF,
   parameter int CNT_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp_hit,
   output logic [ADDR_W-1:0] resp_addr,
   output logic [ADDR_W-1:0] cache_addr,
   input  logic [ADDR_W-1:0] cache_data,
   input  logic              cache_found,
   output logic              cache_we,
   output logic              cache_oe,
   output logic              err,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);

   // The tag field must be non-empty for the cache geometry to make sense.
   if (INDEX_W >= ADDR_W || INDEX_W < 1) begin : g_bad_geometry
      $error("cache_ctrl: INDEX_W must be in 1..ADDR_W-1");
   end

   state_t            state;
   state_t            next;
   logic [ADDR_W-1:0] addr_q;
   logic              hit_q;
   logic              err_q;

   // State, captured address, hit flag and sticky readback error.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         addr_q <= '0;
         hit_q  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         state <= next;
         if (state == IDLE && req_valid)
            addr_q <= req_addr;
         if (state == LOOKUP) begin
            hit_q <= cache_found;
            if (cache_found && (cache_data != addr_q))
               err_q <= 1'b1;
         end
      end
   end

   // Output enable stays low here; the readback half-cycle strobe is produced at the top level.
   always_comb begin
      next       = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      cache_we   = 1'b0;
      cache_oe   = 1'b0;
      case (state)
         IDLE: begin
            req_ready = !rst;
            if (req_valid)
               next = LOOKUP;
         end
         LOOKUP: begin
            next = cache_found ? RESP : FILL;
         end
         FILL: begin
            cache_we = 1'b1;
            next     = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready)
               next = IDLE;
         end
         default: next = IDLE;
      endcase
   end

   assign cache_addr = addr_q;
   assign resp_addr  = addr_q;
   assign resp_hit   = hit_q;
   assign err        = err_q;

`ifdef CACHE_CTRL_STATS_EN
   logic resp_fire;
   assign resp_fire = resp_valid && resp_ready;

   cache_ctrl_stats #(
      .CNT_W(CNT_W)
   ) u_stats (
      .clk      (clk),
      .rst      (rst),
      .hit_inc  (resp_fire && hit_q),
      .miss_inc (resp_fire && !hit_q),
      .hit_cnt  (hit_cnt),
      .miss_cnt (miss_cnt)
   );
`else
   assign hit_cnt  = '0;
   assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with a behavioural tag-cache model; counters built 2 bits wide
// so saturation is reachable when CACHE_CTRL_STATS_EN is defined.
module tb_cache_ctrl;

   localparam int CW = 2;
`ifdef CACHE_CTRL_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic [31:0]   req_addr;
   logic          resp_valid;
   logic          resp_ready;
   logic          resp_hit;
   logic [31:0]   resp_addr;
   logic [31:0]   cache_addr;
   logic [31:0]   cache_data;
   logic          cache_found;
   logic          cache_we;
   logic          cache_oe;
   logic          err;
   logic [CW-1:0] hit_cnt;
   logic [CW-1:0] miss_cnt;

   int checks   = 0;
   int failures = 0;
   int exp_hits = 0;
   int exp_miss = 0;
   logic exp_err = 1'b0;
   logic corrupt = 1'b0;

   logic [17:0] tag_mem   [0:16383];
   logic        valid_mem [0:16383];

   cache_ctrl #(
      .ADDR_W  (32),
      .INDEX_W (14),
      .CNT_W   (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_hit    (resp_hit),
      .resp_addr   (resp_addr),
      .cache_addr  (cache_addr),
      .cache_data  (cache_data),
      .cache_found (cache_found),
      .cache_we    (cache_we),
      .cache_oe    (cache_oe),
      .err         (err),
      .hit_cnt     (hit_cnt),
      .miss_cnt    (miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Direct-mapped tag store: fill on a write strobe, combinational match.
   initial begin
      for (int i = 0; i < 16384; i++) valid_mem[i] = 1'b0;
   end

   always @(posedge clk) begin
      if (cache_we) begin
         valid_mem[cache_addr[13:0]] <= 1'b1;
         tag_mem[cache_addr[13:0]]   <= cache_addr[31:14];
      end
   end

   assign cache_found = valid_mem[cache_addr[13:0]] && (tag_mem[cache_addr[13:0]] == cache_addr[31:14]);
   assign cache_data  = corrupt ? (cache_addr ^ 32'h1) : cache_addr;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic check_counters(input string tag);
      check_output({tag, "_hit_cnt"},  32'(hit_cnt),  STATS ? 32'(exp_hits) : 32'd0);
      check_output({tag, "_miss_cnt"}, 32'(miss_cnt), STATS ? 32'(exp_miss) : 32'd0);
   endtask

   // Full request/response transaction with latency, fill-pulse and response checks.
   task automatic apply_stimulus(input string tag, input logic [31:0] addr, input logic hit);
      int n;
      int we_pulses;
      logic [31:0] we_addr;
      req_valid = 1'b1;
      req_addr  = addr;
      check_output({tag, "_ready"}, 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
      req_addr  = 32'hFFFF_FFFF;
      check_output({tag, "_busy"}, 32'(req_ready), 32'd0);
      n = 1;
      we_pulses = 0;
      we_addr = 32'h0;
      while (!resp_valid && n < 10) begin
         if (cache_we) begin
            we_pulses++;
            we_addr = cache_addr;
         end
         tick();
         n++;
      end
      check_output({tag, "_latency"}, 32'(n), hit ? 32'd2 : 32'd3);
      check_output({tag, "_hit"}, 32'(resp_hit), 32'(hit));
      check_output({tag, "_addr"}, resp_addr, addr);
      check_output({tag, "_we_pulses"}, 32'(we_pulses), hit ? 32'd0 : 32'd1);
      if (!hit) check_output({tag, "_we_addr"}, we_addr, addr);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      if (hit) begin
         if (exp_hits < 3) exp_hits++;
      end else begin
         if (exp_miss < 3) exp_miss++;
      end
      check_output({tag, "_resp_done"}, 32'(resp_valid), 32'd0);
      check_output({tag, "_err"}, 32'(err), 32'(exp_err));
      check_counters(tag);
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = 1'b1;
      req_addr   = 32'h0000_1234;
      resp_ready = 1'b0;
      tick();
      tick();
      check_output("rst_req_ready", 32'(req_ready), 32'd0);
      check_output("rst_resp_valid", 32'(resp_valid), 32'd0);
      check_output("rst_resp_hit", 32'(resp_hit), 32'd0);
      check_output("rst_resp_addr", resp_addr, 32'd0);
      check_output("rst_cache_we", 32'(cache_we), 32'd0);
      check_output("rst_cache_oe", 32'(cache_oe), 32'd0);
      check_output("rst_cache_addr", cache_addr, 32'd0);
      check_output("rst_err", 32'(err), 32'd0);
      check_counters("rst");
      rst       = 1'b0;
      req_valid = 1'b0;
      #1;
      check_output("post_rst_ready", 32'(req_ready), 32'd1);

      $display("[TB] cold miss, repeat hit, conflict");
      apply_stimulus("cold_miss", 32'h0000_1234, 1'b0);
      apply_stimulus("repeat_hit", 32'h0000_1234, 1'b1);
      apply_stimulus("conflict_miss", 32'h0004_1234, 1'b0);
      apply_stimulus("evicted_miss", 32'h0000_1234, 1'b0);

      $display("[TB] backpressure");
      req_valid = 1'b1;
      req_addr  = 32'h0000_1234;
      tick();
      req_addr  = 32'hDEAD_0000;
      tick();
      check_output("bp_valid_start", 32'(resp_valid), 32'd1);
      for (int i = 0; i < 5; i++) tick();
      check_output("bp_valid_hold", 32'(resp_valid), 32'd1);
      check_output("bp_hit_hold", 32'(resp_hit), 32'd1);
      check_output("bp_addr_hold", resp_addr, 32'h0000_1234);
      check_output("bp_ready_low", 32'(req_ready), 32'd0);
      check_output("bp_no_accept", cache_addr, 32'h0000_1234);
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      if (exp_hits < 3) exp_hits++;
      check_output("bp_idle", 32'(req_ready), 32'd1);
      check_counters("bp");

      $display("[TB] readback error");
      corrupt = 1'b1;
      exp_err = 1'b1;
      apply_stimulus("err_hit", 32'h0000_1234, 1'b1);
      corrupt = 1'b0;
      apply_stimulus("err_sticky", 32'h0004_5678, 1'b0);

      $display("[TB] reset during fill");
      req_valid = 1'b1;
      req_addr  = 32'h0000_5678;
      tick();
      req_valid = 1'b0;
      tick();
      check_output("fill_we", 32'(cache_we), 32'd1);
      rst = 1'b1;
      tick();
      exp_hits = 0;
      exp_miss = 0;
      exp_err  = 1'b0;
      check_output("fill_rst_we", 32'(cache_we), 32'd0);
      check_output("fill_rst_valid", 32'(resp_valid), 32'd0);
      check_output("fill_rst_err", 32'(err), 32'd0);
      check_counters("fill_rst");
      rst = 1'b0;
      #1;
      check_output("fill_rst_idle", 32'(req_ready), 32'd1);

      $display("[TB] counter saturation");
      for (int i = 0; i < 5; i++) apply_stimulus("sat_hit", 32'h0000_1234, 1'b1);
      check_output("sat_hit_cnt", 32'(hit_cnt), STATS ? 32'd3 : 32'd0);
      check_output("sat_miss_cnt", 32'(miss_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
